// File: rtl/prbs_checker_pkg.sv
// ============================================================================
// prbs_checker_pkg: LFSR constants and checker state encoding | rev 1.0
// ============================================================================
`default_nettype none

package prbs_checker_pkg;

  localparam int           LFSR_W   = 8;
  // Feedback taps {0,2,3,4} as a mask so generator and checker share one definition
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'b0001_1101;
  localparam logic         FILL_BIT = 1'b1;

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/prbs_predict.sv
// ============================================================================
// prbs_predict: next-bit prediction from the 8-bit history register | rev 1.0
// ============================================================================
`default_nettype none

module prbs_predict
  import prbs_checker_pkg::*;
(
  input  logic [LFSR_W-1:0] s,
  output logic              pred
);

  // All-zero history would lock up the LFSR, so it is forced out with a fill bit
  always_comb begin
    pred = (s == '0) ? FILL_BIT : ^(s & TAP_MASK);
  end

endmodule

`default_nettype wire

// File: rtl/seg_driver.sv
// ============================================================================
// seg_driver: hex digit to active-high {dp,g,f,e,d,c,b,a} pattern | rev 1.0
// ============================================================================
`default_nettype none

module seg_driver (
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'h00;
    case (hex)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
      default: seg = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/prbs_checker.sv
// ============================================================================
// prbs_checker: self-seeding PRBS receiver with error count and lock loss | rev 1.0
// ============================================================================
`default_nettype none

module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int WINDOW      = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_bit,
  input  logic       i_valid,
  input  logic       i_clr,
  output logic       o_locked,
  output logic       o_err,
  output logic [7:0] o_err_cnt,
  output logic [7:0] o_seg0,
  output logic [7:0] o_seg1
);

  localparam int SEED_W = $clog2(LFSR_W);
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WE_W   = WIN_W + 1;
  localparam bit LOSS_EN = (LOSS_THRESH != 0) && (LOSS_THRESH <= WINDOW);
  localparam logic [WE_W-1:0]   LOSS_VAL = WE_W'(LOSS_EN ? LOSS_THRESH : 0);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(LFSR_W - 1);

  state_t              state;
  logic [LFSR_W-1:0]   s;
  logic [SEED_W-1:0]   seed_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic [WE_W-1:0]     win_err;
  logic                pred;
  logic                mismatch;
  logic [WE_W-1:0]     win_err_inc;
  logic                loss;

  prbs_predict u_predict (
    .s    (s),
    .pred (pred)
  );

  always_comb begin
    mismatch    = (state == CHECK) && (i_bit != pred);
    win_err_inc = win_err + {{(WE_W-1){1'b0}}, mismatch};
    loss        = LOSS_EN && mismatch && (win_err_inc == LOSS_VAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      s         <= '0;
      seed_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      o_locked  <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= 8'h00;
    end else begin
      o_err <= 1'b0;

      if (i_clr) begin
        o_err_cnt <= 8'h00;
      end else if (i_valid && mismatch && (o_err_cnt != 8'hFF)) begin
        o_err_cnt <= o_err_cnt + 8'd1;
      end

      if (i_valid) begin
        case (state)
          SEED: begin
            s <= {i_bit, s[LFSR_W-1:1]};
            if (seed_cnt == SEED_LAST) begin
              state    <= CHECK;
              o_locked <= 1'b1;
              seed_cnt <= '0;
            end else begin
              seed_cnt <= seed_cnt + 1'b1;
            end
          end
          CHECK: begin
            // History follows the prediction so one flipped bit is counted once
            s     <= {pred, s[LFSR_W-1:1]};
            o_err <= mismatch;
            if (loss) begin
              state    <= SEED;
              o_locked <= 1'b0;
              seed_cnt <= '0;
              win_cnt  <= '0;
              win_err  <= '0;
            end else if (win_cnt == WIN_LAST) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              win_err <= win_err_inc;
            end
          end
          default: state <= SEED;
        endcase
      end
    end
  end

  seg_driver u_seg0 (
    .hex (o_err_cnt[3:0]),
    .seg (o_seg0)
  );

  seg_driver u_seg1 (
    .hex (o_err_cnt[7:4]),
    .seg (o_seg1)
  );

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker.sv
// ============================================================================
// tb_prbs_checker: directed scenarios against a generator stream | rev 1.0
// ============================================================================
`default_nettype none

module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       valid = 1'b0;
  logic       clr = 1'b0;

  logic       locked, err, nl_locked, nl_err;
  logic [7:0] cnt, seg0, seg1, nl_cnt, nl_seg0, nl_seg1;

  int checks = 0;
  int errors = 0;

  logic stream [0:399];
  logic rec_locked [0:99];
  logic rec_err [0:99];
  logic [7:0] rec_cnt [0:99];

  always #5 clk = ~clk;

  prbs_checker #(.WINDOW(16), .LOSS_THRESH(4)) dut (
    .clk(clk), .rst(rst), .i_bit(bit_in), .i_valid(valid), .i_clr(clr),
    .o_locked(locked), .o_err(err), .o_err_cnt(cnt), .o_seg0(seg0), .o_seg1(seg1)
  );

  prbs_checker #(.WINDOW(16), .LOSS_THRESH(0)) dut_nl (
    .clk(clk), .rst(rst), .i_bit(bit_in), .i_valid(valid), .i_clr(clr),
    .o_locked(nl_locked), .o_err(nl_err), .o_err_cnt(nl_cnt), .o_seg0(nl_seg0), .o_seg1(nl_seg1)
  );

  function automatic logic gen_pred(input logic [7:0] st);
    return (st == 8'h00) ? 1'b1 : (st[0] ^ st[2] ^ st[3] ^ st[4]);
  endfunction

  task automatic build_stream();
    logic [7:0] g;
    logic b;
    g = 8'h00;
    for (int i = 0; i < 400; i++) begin
      b = gen_pred(g);
      stream[i] = b;
      g = {b, g[7:1]};
    end
  endtask

  task automatic send(input logic b, input logic v, input logic c);
    @(negedge clk);
    bit_in = b;
    valid  = v;
    clr    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic inj_loss(input int i);
    return (i == 40) || (i == 42) || (i == 44) || (i == 46);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (locked !== 1'b0 || err !== 1'b0 || cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: locked=%b err=%b cnt=%h, required 0 0 00", locked, err, cnt);
    end
    checks++;
    if (seg0 !== 8'h3F || seg1 !== 8'h3F || nl_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_seg: seg1=%h seg0=%h nl_cnt=%h, required 3f 3f 00", seg1, seg0, nl_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      send(stream[i], 1'b1, 1'b0);
      if (err === 1'b1) pulses++;
      if (i == 6) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL clean_prelock: locked=%b after 7 bits, required 0", locked);
        end
      end
      if (i == 7) begin
        checks++;
        if (locked !== 1'b1) begin
          errors++;
          $display("FAIL clean_lock: locked=%b after 8 bits, required 1", locked);
        end
      end
    end
    checks++;
    if (pulses !== 0 || cnt !== 8'h00 || locked !== 1'b1) begin
      errors++;
      $display("FAIL clean_run: pulses=%0d cnt=%h locked=%b, required 0 00 1", pulses, cnt, locked);
    end
  endtask

  task automatic test_single_error();
    int pulses = 0;
    int where = -1;
    int drops = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      send(stream[i] ^ (i == 50), 1'b1, 1'b0);
      if (err === 1'b1) begin
        pulses++;
        where = i;
      end
      if (i >= 7 && locked !== 1'b1) drops++;
    end
    checks++;
    if (pulses !== 1 || where !== 50) begin
      errors++;
      $display("FAIL single_pulse: pulses=%0d at bit %0d, required 1 at bit 50", pulses, where);
    end
    checks++;
    if (cnt !== 8'h01 || drops !== 0) begin
      errors++;
      $display("FAIL single_count: cnt=%h lock_drops=%0d, required 01 0", cnt, drops);
    end
  endtask

  task automatic test_loss_of_lock();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      send(stream[i] ^ inj_loss(i), 1'b1, 1'b0);
      rec_locked[i] = locked;
      rec_err[i]    = err;
      rec_cnt[i]    = cnt;
      if (err === 1'b1) pulses++;
    end
    checks++;
    if (rec_locked[45] !== 1'b1 || rec_locked[46] !== 1'b0) begin
      errors++;
      $display("FAIL loss_drop: locked@45=%b locked@46=%b, required 1 0", rec_locked[45], rec_locked[46]);
    end
    checks++;
    if (rec_locked[53] !== 1'b0 || rec_locked[54] !== 1'b1) begin
      errors++;
      $display("FAIL loss_relock: locked@53=%b locked@54=%b, required 0 1", rec_locked[53], rec_locked[54]);
    end
    checks++;
    if (pulses !== 4 || rec_err[46] !== 1'b1 || rec_err[40] !== 1'b1) begin
      errors++;
      $display("FAIL loss_pulses: pulses=%0d err@40=%b err@46=%b, required 4 1 1", pulses, rec_err[40], rec_err[46]);
    end
    checks++;
    if (cnt !== 8'h04 || locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_final: cnt=%h locked=%b, required 04 1", cnt, locked);
    end
  endtask

  task automatic test_gaps_and_clear();
    int j = 0;
    logic prev_locked;
    do_reset();
    prev_locked = locked;
    for (int k = 0; k < 2000 && j < 100; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        send(stream[j] ^ inj_loss(j), 1'b1, 1'b0);
        checks++;
        if (locked !== rec_locked[j] || err !== rec_err[j] || cnt !== rec_cnt[j]) begin
          errors++;
          $display("FAIL gap_bit%0d: locked=%b err=%b cnt=%h, required %b %b %h",
                   j, locked, err, cnt, rec_locked[j], rec_err[j], rec_cnt[j]);
        end
        prev_locked = locked;
        j++;
      end else begin
        send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        checks++;
        if (err !== 1'b0 || locked !== prev_locked) begin
          errors++;
          $display("FAIL gap_idle: err=%b locked=%b, required 0 %b", err, locked, prev_locked);
        end
      end
    end
    checks++;
    if (j !== 100) begin
      errors++;
      $display("FAIL gap_budget: consumed %0d bits, required 100", j);
    end
    send(~stream[100], 1'b1, 1'b1);
    checks++;
    if (err !== 1'b1 || cnt !== 8'h00) begin
      errors++;
      $display("FAIL clr_with_err: err=%b cnt=%h, required 1 00", err, cnt);
    end
    send(stream[101], 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 8; i++) send(stream[i], 1'b1, 1'b0);
    for (int i = 8; i < 308; i++) begin
      send(~stream[i], 1'b1, 1'b0);
      if (i == 8) begin
        checks++;
        if (nl_cnt !== 8'h01 || nl_err !== 1'b1) begin
          errors++;
          $display("FAIL sat_first: cnt=%h err=%b, required 01 1", nl_cnt, nl_err);
        end
      end
      if (i == 261) begin
        checks++;
        if (nl_cnt !== 8'hFE) begin
          errors++;
          $display("FAIL sat_254: cnt=%h, required fe", nl_cnt);
        end
      end
      if (i == 262) begin
        checks++;
        if (nl_cnt !== 8'hFF) begin
          errors++;
          $display("FAIL sat_255: cnt=%h, required ff", nl_cnt);
        end
      end
    end
    checks++;
    if (nl_cnt !== 8'hFF || nl_locked !== 1'b1 || nl_err !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: cnt=%h locked=%b err=%b, required ff 1 1", nl_cnt, nl_locked, nl_err);
    end
    checks++;
    if (nl_seg1 !== 8'h71 || nl_seg0 !== 8'h71) begin
      errors++;
      $display("FAIL sat_seg: seg1=%h seg0=%h, required 71 71", nl_seg1, nl_seg0);
    end
  endtask

  task automatic test_reset_mid_check();
    do_reset();
    for (int i = 0; i < 40; i++)
      send(stream[i] ^ ((i == 10) || (i == 20) || (i == 30)), 1'b1, 1'b0);
    checks++;
    if (cnt !== 8'h03 || locked !== 1'b1 || seg0 !== 8'h4F) begin
      errors++;
      $display("FAIL rst_pre: cnt=%h locked=%b seg0=%h, required 03 1 4f", cnt, locked, seg0);
    end
    @(negedge clk);
    rst = 1'b1; valid = 1'b1; bit_in = ~stream[40];
    @(posedge clk);
    #1;
    checks++;
    if (locked !== 1'b0 || cnt !== 8'h00 || err !== 1'b0 || seg0 !== 8'h3F || seg1 !== 8'h3F) begin
      errors++;
      $display("FAIL rst_mid: locked=%b cnt=%h err=%b seg=%h%h, required 0 00 0 3f3f",
               locked, cnt, err, seg1, seg0);
    end
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(stream[i], 1'b1, 1'b0);
      if (i == 6 || i == 7) begin
        checks++;
        if (locked !== (i == 7)) begin
          errors++;
          $display("FAIL rst_relock%0d: locked=%b, required %b", i, locked, (i == 7));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_stream();
    test_reset();
    test_clean();
    test_single_error();
    test_loss_of_lock();
    test_gaps_and_clear();
    test_saturate();
    test_reset_mid_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
